// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer
// Packs a byte stream (valid/ready/last) into the 32-bit word interface of the
// keccak core, honouring the core's buffer_full backpressure. The first byte
// of each word lands in [31:24]. After a message whose length is a multiple of
// four, an extra empty word is sent with is_last=1 and byte_num=0. The number
// of accepted bytes is counted (saturating) and reported on msg_len.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high; discards all state
//   s_byte/s_valid/s_last/s_ready   byte-stream input (transfer = s_valid & s_ready)
//   k_in/k_in_ready/k_is_last/k_byte_num   word to keccak (registered output slot)
//   k_buffer_full  keccak backpressure (word transfer = k_in_ready & ~k_buffer_full)
//   msg_len        bytes accepted since reset, saturating at 2^LEN_W-1
//   done           final word transferred; packer idle until reset
module sha3_byte_packer #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       s_byte,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic [31:0]      k_in,
  output logic             k_in_ready,
  output logic             k_is_last,
  output logic [1:0]       k_byte_num,
  input  logic             k_buffer_full,
  output logic [LEN_W-1:0] msg_len,
  output logic             done
);

  // LAST_FULL is "final word not yet in the slot": it covers both the owed
  // empty terminator and a short final word that arrived while the slot was busy.
  typedef enum logic [1:0] {
    ST_COLLECT   = 2'd0,
    ST_LAST_FULL = 2'd1,
    ST_LAST_PEND = 2'd2,
    ST_DONE      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      acc_q, acc_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             slot_valid_q, slot_valid_d;
  logic [31:0]      slot_data_q, slot_data_d;
  logic             slot_last_q, slot_last_d;
  logic [1:0]       slot_bnum_q, slot_bnum_d;
  logic [LEN_W-1:0] msg_len_q, msg_len_d;
  logic             done_q, done_d;

  logic             s_ready_s;
  logic             accept_s;
  logic             slot_xfer_s;
  logic             slot_free_s;
  logic [31:0]      placed_s;
  logic [31:0]      word_s;

  // Handshake helpers and the word formed by merging the incoming byte.
  always_comb begin
    accept_s    = s_valid & s_ready_s;
    slot_xfer_s = slot_valid_q & ~k_buffer_full;
    slot_free_s = ~slot_valid_q | slot_xfer_s;
    // Byte at count c goes to [31-8c -: 8]; accumulator bytes beyond cnt are zero.
    placed_s    = {s_byte, 24'h000000} >> {cnt_q, 3'b000};
    word_s      = {acc_q, 8'h00} | placed_s;
  end

  // Output decode: byte-side ready depends only on registered state.
  always_comb begin
    s_ready_s = 1'b0;
    if (reset) begin
      s_ready_s = 1'b0;
    end else if (state_q == ST_COLLECT) begin
      s_ready_s = ~((cnt_q == 2'd3) & slot_valid_q);
    end else begin
      s_ready_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_COLLECT: begin
        if (accept_s & s_last) begin
          if (cnt_q == 2'd3) begin
            state_d = ST_LAST_FULL;
          end else if (slot_free_s) begin
            state_d = ST_LAST_PEND;
          end else begin
            state_d = ST_LAST_FULL;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_LAST_FULL: begin
        if (!slot_valid_q) begin
          state_d = ST_LAST_PEND;
        end else begin
          state_d = ST_LAST_FULL;
        end
      end
      ST_LAST_PEND: begin
        if (slot_xfer_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_LAST_PEND;
        end
      end
      ST_DONE: begin
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_COLLECT;
      end
    endcase
  end

  // Datapath: accumulator, output slot, length counter and done flag.
  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    slot_valid_d = slot_valid_q & ~slot_xfer_s;
    slot_data_d  = slot_data_q;
    slot_last_d  = slot_last_q;
    slot_bnum_d  = slot_bnum_q;
    done_d       = done_q;

    if (accept_s && (msg_len_q != {LEN_W{1'b1}})) begin
      msg_len_d = msg_len_q + {{(LEN_W-1){1'b0}}, 1'b1};
    end else begin
      msg_len_d = msg_len_q;
    end

    case (state_q)
      ST_COLLECT: begin
        if (accept_s) begin
          if (cnt_q == 2'd3) begin
            // s_ready guarantees the slot is empty here.
            slot_valid_d = 1'b1;
            slot_data_d  = word_s;
            slot_last_d  = 1'b0;
            slot_bnum_d  = 2'd0;
            acc_d        = 24'h000000;
            cnt_d        = 2'd0;
          end else if (s_last && slot_free_s) begin
            slot_valid_d = 1'b1;
            slot_data_d  = word_s;
            slot_last_d  = 1'b1;
            slot_bnum_d  = cnt_q + 2'd1;
            acc_d        = 24'h000000;
            cnt_d        = 2'd0;
          end else begin
            // Also parks a short final word while the slot is still busy;
            // LAST_FULL then emits it from the accumulator.
            acc_d = word_s[31:8];
            cnt_d = cnt_q + 2'd1;
          end
        end else begin
          acc_d = acc_q;
        end
      end
      ST_LAST_FULL: begin
        if (!slot_valid_q) begin
          // acc/cnt are zero after a full final word, giving the empty terminator.
          slot_valid_d = 1'b1;
          slot_data_d  = {acc_q, 8'h00};
          slot_last_d  = 1'b1;
          slot_bnum_d  = cnt_q;
          acc_d        = 24'h000000;
          cnt_d        = 2'd0;
        end else begin
          acc_d = acc_q;
        end
      end
      ST_LAST_PEND: begin
        if (slot_xfer_s) begin
          done_d = 1'b1;
        end else begin
          done_d = done_q;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        done_d = done_q;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_COLLECT;
      acc_q        <= 24'h000000;
      cnt_q        <= 2'd0;
      slot_valid_q <= 1'b0;
      slot_data_q  <= 32'h00000000;
      slot_last_q  <= 1'b0;
      slot_bnum_q  <= 2'd0;
      msg_len_q    <= {LEN_W{1'b0}};
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      slot_valid_q <= slot_valid_d;
      slot_data_q  <= slot_data_d;
      slot_last_q  <= slot_last_d;
      slot_bnum_q  <= slot_bnum_d;
      msg_len_q    <= msg_len_d;
      done_q       <= done_d;
    end
  end

  assign s_ready    = s_ready_s;
  assign k_in       = slot_data_q;
  assign k_in_ready = slot_valid_q;
  assign k_is_last  = slot_last_q;
  assign k_byte_num = slot_bnum_q;
  assign msg_len    = msg_len_q;
  assign done       = done_q;

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Directed bench for sha3_byte_packer. Two instances share all inputs: one
// with the default 16-bit length counter and one with LEN_W=4 for saturation.
module tb_sha3_byte_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  s_byte = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        k_buffer_full = 1'b0;

  logic        s_ready, k_in_ready, k_is_last, done;
  logic [31:0] k_in;
  logic [1:0]  k_byte_num;
  logic [15:0] msg_len;

  logic        s_ready4, k_in_ready4, k_is_last4, done4;
  logic [31:0] k_in4;
  logic [1:0]  k_byte_num4;
  logic [3:0]  msg_len4;

  int n_cmp = 0;
  int n_fail = 0;

  sha3_byte_packer #(.LEN_W(16)) u_dut (
    .clk(clk), .reset(reset), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .k_in(k_in), .k_in_ready(k_in_ready), .k_is_last(k_is_last),
    .k_byte_num(k_byte_num), .k_buffer_full(k_buffer_full), .msg_len(msg_len), .done(done)
  );

  sha3_byte_packer #(.LEN_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .s_byte(s_byte), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready4), .k_in(k_in4), .k_in_ready(k_in_ready4), .k_is_last(k_is_last4),
    .k_byte_num(k_byte_num4), .k_buffer_full(k_buffer_full), .msg_len(msg_len4), .done(done4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [159:0] msg;      // string, last character in [7:0]
    int           len;
    int           nw;       // expected word transfers
    logic [191:0] w;        // word j at [32*j +: 32]
    logic [1:0]   bn;       // byte_num of the final word
    int           exp_len;
    int           exp_len4;
    bit           stall;    // hold buffer_full for 10 cycles on word 1
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00; k_buffer_full = 1'b0;
    reset = 1'b1;
    #1;
    chk("rst k_in", k_in, 32'h0);
    chk("rst k_in_ready", {31'b0, k_in_ready}, 32'h0);
    chk("rst k_is_last", {31'b0, k_is_last}, 32'h0);
    chk("rst k_byte_num", {30'b0, k_byte_num}, 32'h0);
    chk("rst msg_len", {16'b0, msg_len}, 32'h0);
    chk("rst done", {31'b0, done}, 32'h0);
    chk("rst s_ready", {31'b0, s_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int idx = 0, nx = 0, nx4 = 0, stall = 0, stall_end_idx = -1;
    int last_cyc = -1, done_cyc = -1, sready_bad = 0, stable_bad = 0;
    logic [31:0] held = 32'h0;
    do_reset();
    for (int cyc = 0; cyc < 400 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        chk({tag, " done4"}, {31'b0, done4}, 32'h1);
      end
      if (idx >= v.len && s_ready) sready_bad++;
      // backpressure
      if (v.stall && k_in_ready && nx == 1 && stall < 10) begin
        k_buffer_full = 1'b1;
        if (stall == 0) held = k_in;
        else if (k_in !== held) stable_bad++;
        stall++;
      end else begin
        k_buffer_full = 1'b0;
      end
      // word transfers at the coming edge
      if (k_in_ready && !k_buffer_full) begin
        if (nx < v.nw) begin
          chk({tag, " word"}, k_in, v.w[32*nx +: 32]);
          chk({tag, " is_last"}, {31'b0, k_is_last}, {31'b0, (nx == v.nw-1)});
          if (nx == v.nw-1) chk({tag, " byte_num"}, {30'b0, k_byte_num}, {30'b0, v.bn});
        end else begin
          chk({tag, " extra word"}, nx, v.nw - 1);
        end
        nx++;
        if (nx == v.nw) last_cyc = cyc;
      end
      if (k_in_ready4 && !k_buffer_full) begin
        if (nx4 < v.nw) chk({tag, " word4"}, k_in4, v.w[32*nx4 +: 32]);
        nx4++;
      end
      // byte feed
      if (idx < v.len) begin
        s_valid = 1'b1;
        s_byte  = v.msg[8*(v.len-1-idx) +: 8];
        s_last  = (idx == v.len-1);
        if (s_ready) idx++;
      end else begin
        s_valid = 1'b0; s_last = 1'b0; s_byte = 8'h00;
      end
      if (v.stall && stall == 10 && stall_end_idx < 0) begin
        stall_end_idx = idx;
        chk({tag, " s_ready in stall"}, {31'b0, s_ready}, 32'h0);
      end
    end
    s_valid = 1'b0; s_last = 1'b0; k_buffer_full = 1'b0;
    chk({tag, " transfers"}, nx, v.nw);
    chk({tag, " transfers4"}, nx4, v.nw);
    chk({tag, " done timing"}, done_cyc, (last_cyc < 0) ? -2 : last_cyc + 1);
    chk({tag, " s_ready after last"}, sready_bad, 0);
    chk({tag, " msg_len"}, {16'b0, msg_len}, v.exp_len);
    chk({tag, " msg_len4"}, {28'b0, msg_len4}, v.exp_len4);
    if (v.stall) begin
      chk({tag, " stall cycles"}, stall, 10);
      chk({tag, " stall k_in stable"}, stable_bad, 0);
      chk({tag, " bytes taken by stall end"}, stall_end_idx, 11);
    end
    repeat (3) @(negedge clk);
    chk({tag, " idle k_in_ready"}, {31'b0, k_in_ready}, 32'h0);
    chk({tag, " idle s_ready"}, {31'b0, s_ready}, 32'h0);
    chk({tag, " idle done"}, {31'b0, done}, 32'h1);
    chk({tag, " idle msg_len"}, {16'b0, msg_len}, v.exp_len);
  endtask

  initial begin
    tbl[0].msg = "Hello, world!"; tbl[0].len = 13; tbl[0].nw = 4;
    tbl[0].w = {32'h0, 32'h0, 32'h21000000, 32'h6F726C64, 32'h6F2C2077, 32'h48656C6C};
    tbl[0].bn = 2'd1; tbl[0].exp_len = 13; tbl[0].exp_len4 = 13; tbl[0].stall = 1'b0;

    tbl[1].msg = "The quick brown."; tbl[1].len = 16; tbl[1].nw = 5;
    tbl[1].w = {32'h0, 32'h00000000, 32'h6F776E2E, 32'h6B206272, 32'h71756963, 32'h54686520};
    tbl[1].bn = 2'd0; tbl[1].exp_len = 16; tbl[1].exp_len4 = 15; tbl[1].stall = 1'b0;

    tbl[2].msg = "a"; tbl[2].len = 1; tbl[2].nw = 1;
    tbl[2].w = {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h61000000};
    tbl[2].bn = 2'd1; tbl[2].exp_len = 1; tbl[2].exp_len4 = 1; tbl[2].stall = 1'b0;

    tbl[3] = tbl[0];
    tbl[3].stall = 1'b1;

    tbl[4].msg = "ABCDEFGHIJKLMNOPQRST"; tbl[4].len = 20; tbl[4].nw = 6;
    tbl[4].w = {32'h00000000, 32'h51525354, 32'h4D4E4F50, 32'h494A4B4C, 32'h45464748, 32'h41424344};
    tbl[4].bn = 2'd0; tbl[4].exp_len = 20; tbl[4].exp_len4 = 15; tbl[4].stall = 1'b0;

    tbl[5].msg = "1234567890"; tbl[5].len = 10; tbl[5].nw = 3;
    tbl[5].w = {32'h0, 32'h0, 32'h0, 32'h39300000, 32'h35363738, 32'h31323334};
    tbl[5].bn = 2'd2; tbl[5].exp_len = 10; tbl[5].exp_len4 = 10; tbl[5].stall = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("v%0d", i));

    // Reset in the middle of a stalled message: pending word must vanish at once.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      k_buffer_full = 1'b1;
      s_valid = 1'b1; s_last = 1'b0; s_byte = 8'h7A;
    end
    @(negedge clk);
    s_valid = 1'b0;
    chk("mid k_in_ready before reset", {31'b0, k_in_ready}, 32'h1);
    chk("mid msg_len before reset", {16'b0, msg_len}, 32'd6);
    #2;
    reset = 1'b1;
    #1;
    chk("async k_in_ready", {31'b0, k_in_ready}, 32'h0);
    chk("async k_in", k_in, 32'h0);
    chk("async msg_len", {16'b0, msg_len}, 32'h0);
    chk("async s_ready", {31'b0, s_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    k_buffer_full = 1'b0;
    run_vec(tbl[5], "v5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sha3_byte_packer.md
Name: sha3_byte_packer

Overview:
Upstream feeder for the keccak core. It accepts a byte stream with valid/ready/last handshaking and packs it into the 32-bit word interface the core expects (in, in_ready, is_last, byte_num), honouring the core's buffer_full backpressure. It generates the final-word encoding, including the extra empty terminating word for messages whose length is a multiple of 4. It also reports the message length in bytes.

Parameters:
LEN_W, 16, width of the message byte-length counter; saturates at 2^LEN_W-1

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  asynchronous, active-high reset; clears all state
s_byte  input  8  message byte
s_valid  input  1  s_byte valid
s_last  input  1  qualifies s_byte as final byte of message
s_ready  output  1  packer accepts byte this cycle (transfer = s_valid & s_ready)
k_in  output  32  word to keccak in; first byte of word in [31:24]
k_in_ready  output  1  to keccak in_ready; word offered
k_is_last  output  1  to keccak is_last
k_byte_num  output  2  to keccak byte_num; valid bytes in final word (0..3)
k_buffer_full  input  1  from keccak buffer_full; word transfer = k_in_ready & ~k_buffer_full
msg_len  output  LEN_W  bytes accepted since reset, saturating
done  output  1  final word transferred; packer idle until reset

Behaviour:
- Reset (async): k_in=0, k_in_ready=0, k_is_last=0, k_byte_num=0, msg_len=0, done=0, accumulator count=0, state COLLECT. s_ready reads 0 while reset is high.
- Storage: accumulator acc[23:0] plus cnt (0..3); output slot holds registered k_in/k_is_last/k_byte_num and a valid bit (drives k_in_ready).
- Byte placement: the byte accepted at cnt=c goes to bits [31-8c -: 8] of the word. Unused low bytes are 0.
- States: COLLECT, LAST_FULL (full word pending, empty terminator still owed), LAST_PEND (final word in slot), DONE.
- s_ready = (state==COLLECT) & ~(cnt==3 & slot_valid). There is no combinational path from k_buffer_full to s_ready.
- COLLECT, byte accepted, not last, cnt<3: store the byte; cnt++.
- COLLECT, byte accepted, not last, cnt==3: load the slot with {acc, byte}, is_last=0, byte_num=0; cnt=0. k_in_ready is high the next cycle (1-cycle latency).
- COLLECT, byte accepted with s_last, cnt<3: load the slot with the partial word, is_last=1, byte_num=cnt+1; go to LAST_PEND. s_ready is 0 from then on.
- COLLECT, byte accepted with s_last, cnt==3: load the slot with the full word, is_last=0, byte_num=0; go to LAST_FULL.
- LAST_FULL: once the slot transfers, the next cycle loads the slot with k_in=0, is_last=1, byte_num=0; go to LAST_PEND.
- LAST_PEND: once the slot transfers, go to DONE and set done=1.
- DONE: s_ready=0, k_in_ready=0. Only reset leaves this state.
- Slot rule: the slot holds k_in, k_is_last and k_byte_num stable while k_in_ready=1 & k_buffer_full=1. On transfer the slot clears (k_in_ready=0) unless it is reloaded in the same cycle.
- Slot never overwritten: the slot is only loaded when empty or transferring this cycle; s_ready gating guarantees this.
- msg_len increments on every accepted byte and saturates at the maximum. It holds its value in DONE.
- Zero-length messages are not supported; a message always has at least one byte carrying s_last.
- s_valid while s_ready=0: ignored; byte not consumed.
- Reset asserted mid-message or mid-stall: all state and the pending word are discarded immediately, and k_in_ready drops asynchronously.

Test Plan:
- "Hello, world!" (13 bytes) at 1 byte/cycle, k_buffer_full=0 -> words 0x48656C6C, 0x6F2C2077, 0x6F726C64, then 0x21000000 with k_is_last=1, k_byte_num=1; msg_len=13; done=1 one cycle after the last transfer.
- "The quick brown." (16 bytes) -> four words with is_last=0, then k_in=0, k_is_last=1, k_byte_num=0; exactly 5 transfers total.
- Single byte "a" with s_last -> one word 0x61000000, is_last=1, byte_num=1; after that s_ready stays 0.
- k_buffer_full held high for 10 cycles while the 2nd word "o, w" is pending -> k_in stays stable; s_ready drops after the 3 bytes of the next word (cnt==3); no bytes or words are lost or duplicated; the sequence resumes once full=0.
- Reset pulsed after 6 bytes of a message, then "1234567890" sent -> 0x31323334, 0x35363738, 0x39300000 with byte_num=2, is_last=1; msg_len=10.
- msg_len saturation with LEN_W=4: 20 bytes sent -> msg_len=15; packing unaffected (5 full words plus an empty last word).
